snake_step_sequencer: RTL and testbench

Game-flow controller for the snake datapath. Paces snake steps from VGA frame ticks and issues one-cycle command pulses to the game datapath in a fixed order: move, collision check, grow, fruit spawn. Also owns lives, pause, game-over and speed-up state. Sits between the VGA timing (frame tick) and the snake game core, replacing free-running step timing inside the core.

---
 rtl/snake_step_sequencer_pkg.sv | 42 ++++
 rtl/snake_step_sequencer_btn_edge_detect.sv | 23 ++
 rtl/snake_step_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_snake_step_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_step_sequencer_pkg.sv
// Shared encodings and widths for the snake game-flow sequencer.
// The lives width matches the game core so the counter can be wired across directly.
package snake_step_sequencer_pkg;

  localparam int STATE_WIDTH     = 4;
  localparam int LIVES_WIDTH     = 3;
  localparam int FPS_WIDTH       = 6;
  localparam int FRAME_CNT_WIDTH = 7;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE       = 4'd0;
  localparam logic [STATE_WIDTH-1:0] ST_RESPAWN    = 4'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_FRAME = 4'd2;
  localparam logic [STATE_WIDTH-1:0] ST_MOVE       = 4'd3;
  localparam logic [STATE_WIDTH-1:0] ST_CHECK      = 4'd4;
  localparam logic [STATE_WIDTH-1:0] ST_GROW       = 4'd5;
  localparam logic [STATE_WIDTH-1:0] ST_SPAWN      = 4'd6;
  localparam logic [STATE_WIDTH-1:0] ST_PAUSED     = 4'd7;
  localparam logic [STATE_WIDTH-1:0] ST_OVER       = 4'd8;

  typedef struct packed {
    logic respawn_en;
    logic move_en;
    logic check_req;
    logic grow_en;
    logic spawn_req;
  } cmd_t;

  // Command pulses for the cycle after a transition. Multi-cycle states only pulse
  // on entry, so each command fires exactly once per visit.
  function automatic cmd_t cmd_decode(input logic [STATE_WIDTH-1:0] cur,
                                      input logic [STATE_WIDTH-1:0] nxt);
    cmd_t c;
    c            = '0;
    c.respawn_en = (nxt == ST_RESPAWN) && (cur != ST_RESPAWN);
    c.move_en    = (nxt == ST_MOVE);
    c.check_req  = (nxt == ST_CHECK) && (cur != ST_CHECK);
    c.grow_en    = (nxt == ST_GROW);
    c.spawn_req  = (nxt == ST_SPAWN) && (cur != ST_SPAWN);
    return c;
  endfunction

endpackage

// File: rtl/snake_step_sequencer_btn_edge_detect.sv
// Rising-edge detector for a debounced button level.
// The previous value resets high so a button held through reset produces no edge.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      prev_q <= btn;
    end
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/snake_step_sequencer.sv
// Game-flow controller: paces snake steps from frame ticks and issues one-cycle
// move/check/grow/spawn commands, while owning lives, pause, game-over and speed-up.
module snake_step_sequencer
  import snake_step_sequencer_pkg::*;
#(
  parameter int FRAMES_PER_STEP_INIT = 8,
  parameter int MIN_FRAMES           = 2,
  parameter int SPEEDUP_EVERY        = 4,
  parameter int LIVES_INIT           = 3,
  parameter int RESPAWN_FRAMES       = 60,
  parameter int ACK_TIMEOUT          = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   btn_start,
  input  logic                   btn_pause,
  input  logic                   check_done,
  input  logic                   collision,
  input  logic                   fruit_hit,
  input  logic                   spawn_done,
  output logic                   respawn_en,
  output logic                   move_en,
  output logic                   check_req,
  output logic                   grow_en,
  output logic                   score_inc,
  output logic                   spawn_req,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [FPS_WIDTH-1:0]   frames_per_step,
  output logic                   game_over,
  output logic                   paused,
  output logic                   seq_error
);

  localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int FRUIT_W = $clog2(SPEEDUP_EVERY + 1);

  localparam logic [ACK_W-1:0]           ACK_LAST       = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [FRUIT_W-1:0]         FRUIT_LAST     = FRUIT_W'(SPEEDUP_EVERY - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] RESPAWN_TARGET = FRAME_CNT_WIDTH'(RESPAWN_FRAMES);
  localparam logic [FPS_WIDTH-1:0]       FPS_INIT       = FPS_WIDTH'(FRAMES_PER_STEP_INIT);
  localparam logic [FPS_WIDTH-1:0]       FPS_MIN        = FPS_WIDTH'(MIN_FRAMES);
  localparam logic [LIVES_WIDTH-1:0]     LIVES_START    = LIVES_WIDTH'(LIVES_INIT);

  logic [STATE_WIDTH-1:0]     state_q, state_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_inc;
  logic [ACK_W-1:0]           ack_cnt_q;
  logic [FRUIT_W-1:0]         fruit_cnt_q;
  logic [LIVES_WIDTH-1:0]     lives_q;
  logic [FPS_WIDTH-1:0]       fps_q;
  logic                       seq_error_q, paused_q, game_over_q;
  cmd_t                       cmd_q;

  logic start_rise, pause_rise;
  logic start_load, ack_expired, timeout;

  btn_edge_detect u_start_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .rise  (start_rise)
  );

  btn_edge_detect u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_pause),
    .rise  (pause_rise)
  );

  assign frame_cnt_inc = frame_cnt_q + 1'b1;
  assign ack_expired   = (ack_cnt_q == ACK_LAST);
  assign start_load    = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_rise;
  assign timeout       = ack_expired &&
                         (((state_q == ST_CHECK) && !check_done) ||
                          ((state_q == ST_SPAWN) && !spawn_done));

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) state_d = ST_RESPAWN;
      end
      ST_RESPAWN: begin
        if (frame_tick && (frame_cnt_inc == RESPAWN_TARGET)) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        // Pause wins over a same-cycle tick; that tick is simply dropped.
        if (pause_rise)                                         state_d = ST_PAUSED;
        else if (frame_tick && (frame_cnt_inc == {1'b0, fps_q})) state_d = ST_MOVE;
      end
      ST_PAUSED: begin
        if (pause_rise) state_d = ST_WAIT_FRAME;
      end
      ST_MOVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (check_done) begin
          if (collision)      state_d = (lives_q > 1) ? ST_RESPAWN : ST_OVER;
          else if (fruit_hit) state_d = ST_GROW;
          else                state_d = ST_WAIT_FRAME;
        end else if (ack_expired) begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_GROW: state_d = ST_SPAWN;
      ST_SPAWN: begin
        if (spawn_done || ack_expired) state_d = ST_WAIT_FRAME;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      ack_cnt_q   <= '0;
      fruit_cnt_q <= '0;
      lives_q     <= '0;
      fps_q       <= FPS_INIT;
      seq_error_q <= 1'b0;
      paused_q    <= 1'b0;
      game_over_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_decode(state_q, state_d);
      paused_q    <= (state_d == ST_PAUSED);
      game_over_q <= (state_d == ST_OVER);

      // Frame counter is shared by RESPAWN and WAIT_FRAME; it is held across a pause.
      case (state_q)
        ST_RESPAWN, ST_WAIT_FRAME: begin
          if (state_d == ST_PAUSED)   frame_cnt_q <= frame_cnt_q;
          else if (state_d != state_q) frame_cnt_q <= '0;
          else if (frame_tick)         frame_cnt_q <= frame_cnt_inc;
        end
        default: begin
          if (state_d == ST_RESPAWN) frame_cnt_q <= '0;
        end
      endcase

      if (((state_d == ST_CHECK) && (state_q != ST_CHECK)) ||
          ((state_d == ST_SPAWN) && (state_q != ST_SPAWN))) begin
        ack_cnt_q <= '0;
      end else if ((state_q == ST_CHECK) || (state_q == ST_SPAWN)) begin
        ack_cnt_q <= ack_cnt_q + 1'b1;
      end

      if (start_load) begin
        lives_q     <= LIVES_START;
        fps_q       <= FPS_INIT;
        fruit_cnt_q <= '0;
        seq_error_q <= 1'b0;
      end else begin
        if ((state_q == ST_CHECK) && check_done && collision && (lives_q != '0)) begin
          lives_q <= lives_q - 1'b1;
        end
        if (state_q == ST_GROW) begin
          if (fruit_cnt_q == FRUIT_LAST) begin
            fruit_cnt_q <= '0;
            if (fps_q > FPS_MIN) fps_q <= fps_q - 1'b1;
          end else begin
            fruit_cnt_q <= fruit_cnt_q + 1'b1;
          end
        end
        if (timeout) seq_error_q <= 1'b1;
      end
    end
  end

  assign respawn_en      = cmd_q.respawn_en;
  assign move_en         = cmd_q.move_en;
  assign check_req       = cmd_q.check_req;
  assign grow_en         = cmd_q.grow_en;
  assign score_inc       = cmd_q.grow_en;
  assign spawn_req       = cmd_q.spawn_req;
  assign lives           = lives_q;
  assign frames_per_step = fps_q;
  assign game_over       = game_over_q;
  assign paused          = paused_q;
  assign seq_error       = seq_error_q;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer: start, fruit/speed-up, timeout, collisions,
// game over, pause and asynchronous reset, with hand-computed expectations.
module tb_snake_step_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, btn_start, btn_pause;
  logic       check_done, collision, fruit_hit, spawn_done;
  logic       respawn_en, move_en, check_req, grow_en, score_inc, spawn_req;
  logic [2:0] lives;
  logic [5:0] frames_per_step;
  logic       game_over, paused, seq_error;

  int total = 0;
  int bad   = 0;
  int n_respawn = 0, n_move = 0, n_check = 0, n_grow = 0, n_score = 0, n_spawn = 0, n_multi = 0;

  int exp_fps, exp_fruit;
  int snap_move, snap_grow, snap_spawn, snap_respawn, snap_all;

  snake_step_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .btn_start       (btn_start),
    .btn_pause       (btn_pause),
    .check_done      (check_done),
    .collision       (collision),
    .fruit_hit       (fruit_hit),
    .spawn_done      (spawn_done),
    .respawn_en      (respawn_en),
    .move_en         (move_en),
    .check_req       (check_req),
    .grow_en         (grow_en),
    .score_inc       (score_inc),
    .spawn_req       (spawn_req),
    .lives           (lives),
    .frames_per_step (frames_per_step),
    .game_over       (game_over),
    .paused          (paused),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    n_respawn <= n_respawn + int'(respawn_en);
    n_move    <= n_move    + int'(move_en);
    n_check   <= n_check   + int'(check_req);
    n_grow    <= n_grow    + int'(grow_en);
    n_score   <= n_score   + int'(score_inc);
    n_spawn   <= n_spawn   + int'(spawn_req);
    if ((int'(respawn_en) + int'(move_en) + int'(check_req) + int'(grow_en) + int'(spawn_req)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  // One full step from WAIT_FRAME: nticks frames, MOVE, CHECK answered on its first cycle.
  task automatic run_step(input int nticks, input logic col, input logic fr);
    pulse_ticks(nticks - 1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    check_done = 1'b1;
    collision  = col;
    fruit_hit  = fr;
    tick();
    check_done = 1'b0;
    collision  = 1'b0;
    fruit_hit  = 1'b0;
    if (!col && fr) begin
      tick();
      spawn_done = 1'b1;
      tick();
      spawn_done = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    btn_start  = 1'b1;
    btn_pause  = 1'b0;
    check_done = 1'b0;
    collision  = 1'b0;
    fruit_hit  = 1'b0;
    spawn_done = 1'b0;
    repeat (3) tick();

    check("rst_lives", lives, 0);
    check("rst_fps", frames_per_step, 8);
    check("rst_game_over", game_over, 0);
    check("rst_paused", paused, 0);
    check("rst_seq_error", seq_error, 0);
    check("rst_pulses", {respawn_en, move_en, check_req, grow_en, spawn_req}, 0);

    // Start held through reset must not produce an edge.
    reset = 1'b1;
    repeat (3) tick();
    check("held_start_no_respawn", n_respawn, 0);
    btn_start = 1'b0;
    tick();

    // Start edge: respawn_en on the very next cycle, once.
    btn_start = 1'b1;
    tick();
    check("start_respawn_en", respawn_en, 1);
    check("start_lives", lives, 3);
    tick();
    check("respawn_one_cycle", respawn_en, 0);
    btn_start = 1'b0;

    // 60 respawn frames, then 7 frames of the 8-frame step without a move.
    pulse_ticks(60);
    pulse_ticks(7);
    check("no_move_before_8th", n_move, 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("first_move_en", move_en, 1);
    check("first_move_no_check", check_req, 0);
    tick();
    check("first_check_req", check_req, 1);
    check("move_one_cycle", move_en, 0);

    // Fruit answered in the first CHECK cycle.
    check_done = 1'b1;
    fruit_hit  = 1'b1;
    tick();
    check_done = 1'b0;
    fruit_hit  = 1'b0;
    check("fruit_grow_en", grow_en, 1);
    check("fruit_score_inc", score_inc, 1);
    tick();
    check("fruit_spawn_req", spawn_req, 1);
    check("grow_one_cycle", grow_en, 0);
    spawn_done = 1'b1;
    tick();
    spawn_done = 1'b0;
    check("first_step_moves", n_move, 1);

    // Speed-up model: every 4 fruits the period drops by one, floored at 2.
    exp_fps   = 8;
    exp_fruit = 1;
    for (int f = 2; f <= 28; f++) begin
      run_step(exp_fps, 1'b0, 1'b1);
      exp_fruit++;
      if (exp_fruit == 4) begin
        exp_fruit = 0;
        if (exp_fps > 2) exp_fps--;
      end
      if (f == 4)  check("fps_after_4", frames_per_step, 7);
      if (f == 24) check("fps_after_24", frames_per_step, 2);
    end
    check("fps_floor_after_28", frames_per_step, 2);
    check("grow_count_28", n_grow, 28);
    check("score_count_28", n_score, 28);
    check("spawn_count_28", n_spawn, 28);

    // Withhold check_done: timeout after 15 CHECK cycles.
    pulse_ticks(1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    check("to_check_req", check_req, 1);
    repeat (14) tick();
    check("to_not_yet", seq_error, 0);
    tick();
    check("to_seq_error", seq_error, 1);
    snap_move = n_move;
    run_step(2, 1'b0, 1'b0);
    check("to_back_in_wait", n_move, snap_move + 1);
    check("to_sticky", seq_error, 1);

    // Collision beats fruit: lose a life, no grow, no spawn.
    snap_grow  = n_grow;
    snap_spawn = n_spawn;
    run_step(2, 1'b1, 1'b1);
    check("prio_lives", lives, 2);
    check("prio_respawn_en", respawn_en, 1);
    tick();
    check("prio_no_grow", n_grow, snap_grow);
    check("prio_no_spawn", n_spawn, snap_spawn);
    pulse_ticks(60);

    run_step(2, 1'b1, 1'b0);
    check("life2_lives", lives, 1);
    check("life2_respawn_en", respawn_en, 1);
    pulse_ticks(60);

    snap_respawn = n_respawn;
    run_step(2, 1'b1, 1'b0);
    check("over_lives", lives, 0);
    check("over_game_over", game_over, 1);
    tick();
    check("over_no_respawn", n_respawn, snap_respawn);

    // Restart from OVER.
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    check("restart_seq_error", seq_error, 0);
    check("restart_fps", frames_per_step, 8);
    check("restart_respawn_en", respawn_en, 1);
    pulse_ticks(60);

    // Pause after 5 of 8 frames; 100 frames pass with no move.
    pulse_ticks(5);
    btn_pause = 1'b1;
    tick();
    check("pause_paused", paused, 1);
    snap_move = n_move;
    pulse_ticks(100);
    check("pause_no_move", n_move, snap_move);
    check("pause_still_paused", paused, 1);
    btn_pause = 1'b0;
    tick();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
    check("unpause_paused", paused, 0);
    pulse_ticks(2);
    check("unpause_no_move_yet", n_move, snap_move);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("unpause_move_3rd", move_en, 1);
    tick();

    // Pause edge during CHECK is ignored.
    btn_pause = 1'b1;
    tick();
    check("check_pause_ignored", paused, 0);
    check_done = 1'b1;
    fruit_hit  = 1'b1;
    tick();
    check_done = 1'b0;
    fruit_hit  = 1'b0;
    check("check_pause_grow", grow_en, 1);
    tick();
    check("spawn_before_reset", spawn_req, 1);
    btn_pause = 1'b0;

    // Asynchronous reset in the middle of SPAWN.
    #2;
    reset = 1'b0;
    #1;
    check("arst_spawn_req", spawn_req, 0);
    check("arst_lives", lives, 0);
    check("arst_fps", frames_per_step, 8);
    check("arst_flags", {game_over, paused, seq_error}, 0);
    snap_all = n_respawn + n_move + n_check + n_grow + n_spawn;
    repeat (4) tick();
    reset = 1'b1;
    repeat (6) tick();
    check("arst_no_pulses", n_respawn + n_move + n_check + n_grow + n_spawn, snap_all);
    check("one_pulse_per_cycle", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
